// File: rtl/alu_op_sequencer.sv
// Front-end controller for the lab ALU: collects A, B and opcode from a shared strobed bus.
// It holds the operands stable while the ALU settles, then keeps the captured result until it is acknowledged.
module alu_op_sequencer #(
  parameter int N      = 6,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  input  logic         cancel,
  input  logic         result_ack,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_out,
  input  logic         alu_z,
  input  logic         alu_o,
  input  logic         alu_ca,
  input  logic         alu_neg,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         err,
  output logic         result_valid,
  output logic         busy,
  output logic [2:0]   state_dbg,
  output logic [7:0]   op_count
);

  // Handshake: in_valid is a one-cycle strobe that is accepted only in the LOAD_* states,
  // or in DONE together with result_ack. result_valid stays high for as long as the FSM is in DONE.
  // It drops on the cycle after result_ack or cancel is seen.

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  state_t        state, state_next;
  logic [CW-1:0] settle_cnt;
  logic          load_a, load_b, load_op;
  logic          fast_err, capture, cnt_clr, cnt_inc;
  logic [3:0]    op_code;
  logic          op_bad;

  assign op_code = in_data[3:0];
  // Division and modulo by zero are caught here, before the ALU is ever exercised.
  assign op_bad  = (op_code > 4'd9) ||
                   (((op_code == 4'd3) || (op_code == 4'd4)) && (alu_b == '0));

  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    fast_err   = 1'b0;
    capture    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (cancel) begin
      state_next = LOAD_A;
    end else begin
      case (state)
        LOAD_A: if (in_valid) begin
          load_a     = 1'b1;
          state_next = LOAD_B;
        end
        LOAD_B: if (in_valid) begin
          load_b     = 1'b1;
          state_next = LOAD_OP;
        end
        LOAD_OP: if (in_valid) begin
          load_op = 1'b1;
          if (op_bad) begin
            fast_err   = 1'b1;
            state_next = DONE;
          end else begin
            cnt_clr    = 1'b1;
            state_next = EXEC;
          end
        end
        EXEC: if (settle_cnt == CNT_LAST) begin
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
        DONE: if (result_ack) begin
          state_next = LOAD_A;
          if (in_valid) begin
            load_a     = 1'b1;
            state_next = LOAD_B;
          end
        end
        default: state_next = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_A;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      result     <= '0;
      flags      <= '0;
      err        <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_next;
      if (load_a)  alu_a   <= in_data;
      if (load_b)  alu_b   <= in_data;
      if (load_op) begin
        alu_sel <= op_code;
        err     <= fast_err;
      end
      if (fast_err) begin
        result <= '0;
        flags  <= '0;
      end
      if (capture) begin
        result <= alu_out;
        flags  <= {alu_neg, alu_ca, alu_o, alu_z};
      end
      if (cnt_clr)      settle_cnt <= '0;
      else if (cnt_inc) settle_cnt <= settle_cnt + 1'b1;
      if ((state_next == DONE) && (state != DONE)) op_count <= op_count + 8'd1;
    end
  end

  assign result_valid = (state == DONE);
  assign busy         = (state == EXEC);
  assign state_dbg    = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a behavioural 6-bit ALU closes the loop.
// One instance runs with SETTLE=1 and a second instance runs with SETTLE=3.
module tb_alu_op_sequencer;

  localparam int N = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles;
  int exp_ops;

  // ---- SETTLE=1 instance ----
  logic         rst, in_valid, cancel, result_ack;
  logic [N-1:0] in_data, alu_a, alu_b, alu_out, result;
  logic [3:0]   alu_sel, flags;
  logic         alu_z, alu_o, alu_ca, alu_neg, err, result_valid, busy;
  logic [2:0]   state_dbg;
  logic [7:0]   op_count;

  // ---- SETTLE=3 instance ----
  logic         rst3, in_valid3, cancel3, result_ack3;
  logic [N-1:0] in_data3, alu_a3, alu_b3, alu_out3, result3;
  logic [3:0]   alu_sel3, flags3;
  logic         alu_z3, alu_o3, alu_ca3, alu_neg3, err3, result_valid3, busy3;
  logic [2:0]   state_dbg3;
  logic [7:0]   op_count3;

  // Returns {neg, ca, o, z, out}.
  function automatic logic [9:0] alu_model(input logic [5:0] a, input logic [5:0] b,
                                           input logic [3:0] sel);
    logic [6:0]  w;
    logic [11:0] m;
    logic [5:0]  r;
    logic        ca, o;
    w = '0; m = '0; r = '0; ca = 1'b0; o = 1'b0;
    case (sel)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[5:0]; ca = w[6];
                  o = (a[5] == b[5]) && (r[5] != a[5]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[5:0]; ca = w[6];
                  o = (a[5] != b[5]) && (r[5] != a[5]); end
      4'd2: begin m = {6'b0, a} * {6'b0, b}; r = m[5:0]; ca = |m[11:6]; end
      4'd3: r = (b == 6'd0) ? 6'd0 : a / b;
      4'd4: r = (b == 6'd0) ? 6'd0 : a % b;
      4'd5: r = a << b[2:0];
      4'd6: r = a >> b[2:0];
      4'd7: r = a & b;
      4'd8: r = a | b;
      4'd9: r = a ^ b;
      default: r = '0;
    endcase
    return {r[5], ca, o, (r == 6'd0), r};
  endfunction

  always_comb {alu_neg, alu_ca, alu_o, alu_z, alu_out} = alu_model(alu_a, alu_b, alu_sel);
  always_comb {alu_neg3, alu_ca3, alu_o3, alu_z3, alu_out3} = alu_model(alu_a3, alu_b3, alu_sel3);

  alu_op_sequencer #(.N(N), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .cancel(cancel),
    .result_ack(result_ack), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_z(alu_z), .alu_o(alu_o), .alu_ca(alu_ca), .alu_neg(alu_neg),
    .result(result), .flags(flags), .err(err), .result_valid(result_valid), .busy(busy),
    .state_dbg(state_dbg), .op_count(op_count)
  );

  alu_op_sequencer #(.N(N), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .cancel(cancel3),
    .result_ack(result_ack3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
    .alu_out(alu_out3), .alu_z(alu_z3), .alu_o(alu_o3), .alu_ca(alu_ca3), .alu_neg(alu_neg3),
    .result(result3), .flags(flags3), .err(err3), .result_valid(result_valid3), .busy(busy3),
    .state_dbg(state_dbg3), .op_count(op_count3)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [N-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic strobe3(input logic [N-1:0] d);
    in_data3  = d;
    in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; cancel = 1'b0; result_ack = 1'b0; in_data = '0;
    rst3 = 1'b1; in_valid3 = 1'b0; cancel3 = 1'b0; result_ack3 = 1'b0; in_data3 = '0;
    #1;
    tick(); tick();
    rst = 1'b0; rst3 = 1'b0;

    // Reset state
    chk("rst_state", state_dbg, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", op_count, 0);

    // 5 + 3: EXEC for one cycle, valid two cycles after the opcode strobe
    strobe(6'd5);
    strobe(6'd3);
    chk("add_state_op", state_dbg, 2);
    chk("add_alu_b", alu_b, 3);
    strobe(6'd0);
    chk("add_busy", busy, 1);
    chk("add_valid_early", result_valid, 0);
    tick();
    chk("add_valid", result_valid, 1);
    chk("add_result", result, 8);
    chk("add_flags", flags, 4'b0000);
    chk("add_err", err, 0);
    chk("add_count", op_count, 1);
    ack();
    chk("add_ack_state", state_dbg, 0);
    chk("add_ack_valid", result_valid, 0);
    chk("add_hold_a", alu_a, 5);

    // 9 / 0: fast error path, valid one cycle after the strobe
    strobe(6'd9);
    strobe(6'd0);
    strobe(6'd3);
    chk("div0_valid", result_valid, 1);
    chk("div0_err", err, 1);
    chk("div0_result", result, 0);
    chk("div0_count", op_count, 2);
    ack();

    // Invalid opcode 12
    strobe(6'd9);
    strobe(6'd4);
    strobe(6'd12);
    chk("inv_valid", result_valid, 1);
    chk("inv_err", err, 1);
    chk("inv_count", op_count, 3);
    ack();

    // 0x2A & 0x15 = 0 -> Z flag; then ack with in_valid in the same cycle
    strobe(6'h2A);
    strobe(6'h15);
    strobe(6'd7);
    tick();
    chk("and_result", result, 0);
    chk("and_flags", flags, 4'b0001);
    chk("and_err", err, 0);
    in_data = 6'h07; in_valid = 1'b1; result_ack = 1'b1;
    tick();
    in_valid = 1'b0; result_ack = 1'b0;
    chk("ackin_state", state_dbg, 1);
    chk("ackin_alu_a", alu_a, 6'h07);
    chk("ackin_valid", result_valid, 0);
    chk("ackin_count", op_count, 4);

    // cancel in LOAD_OP, with a competing in_valid
    strobe(6'd4);
    chk("cancel_pre_state", state_dbg, 2);
    cancel = 1'b1; in_valid = 1'b1; in_data = 6'd0;
    tick();
    cancel = 1'b0; in_valid = 1'b0;
    chk("cancel_state", state_dbg, 0);
    chk("cancel_valid", result_valid, 0);
    chk("cancel_count", op_count, 4);
    chk("cancel_sel_kept", alu_sel, 7);

    // cancel in EXEC must not capture
    strobe(6'd2);
    strobe(6'd3);
    strobe(6'd0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("xcancel_state", state_dbg, 0);
    chk("xcancel_busy", busy, 0);
    chk("xcancel_result", result, 0);
    chk("xcancel_count", op_count, 4);

    // 1 | 1 = 1, then in_valid in DONE without ack is ignored
    strobe(6'd1);
    strobe(6'd1);
    strobe(6'd8);
    tick();
    chk("or_result", result, 1);
    strobe(6'h3F);
    tick();
    chk("noack_result", result, 1);
    chk("noack_state", state_dbg, 4);
    chk("noack_alu_a", alu_a, 1);
    chk("noack_count", op_count, 5);
    ack();

    // Back-to-back ops until op_count wraps past 255
    exp_ops = 5;
    for (int i = 0; i < 251; i++) begin
      strobe(6'd1);
      strobe(6'd1);
      strobe(6'd8);
      tick();
      exp_ops++;
      if (exp_ops == 255) chk("count_255", op_count, 255);
      ack();
    end
    chk("count_wrap", op_count, exp_ops % 256);
    chk("count_wrap_zero", op_count, 0);
    chk("wrap_result", result, 1);

    // SETTLE=3: busy for exactly three cycles
    strobe3(6'd5);
    strobe3(6'd3);
    strobe3(6'd0);
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (result_valid3) break;
      if (busy3) busy_cycles++;
      tick();
    end
    chk("s3_busy_cycles", busy_cycles, 3);
    chk("s3_valid", result_valid3, 1);
    chk("s3_result", result3, 8);
    chk("s3_count", op_count3, 1);
    result_ack3 = 1'b1;
    tick();
    result_ack3 = 1'b0;

    // SETTLE=3: reset during the second EXEC cycle zeroes everything
    strobe3(6'd6);
    strobe3(6'd2);
    strobe3(6'd2);
    chk("s3_exec1_busy", busy3, 1);
    tick();
    chk("s3_exec2_busy", busy3, 1);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    chk("s3_rst_state", state_dbg3, 0);
    chk("s3_rst_busy", busy3, 0);
    chk("s3_rst_valid", result_valid3, 0);
    chk("s3_rst_result", result3, 0);
    chk("s3_rst_alu", {alu_a3, alu_b3, alu_sel3}, 0);
    chk("s3_rst_flags_err", {flags3, err3}, 0);
    chk("s3_rst_count", op_count3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
